// File: rtl/retire_trace_fifo.sv
// Retirement trace monitor: classifies and stamps each retire event and buffers it
// in a FIFO drained by a valid/ready sink; a halt record is never lost.
module retire_trace_fifo #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ret_valid,
    input  logic [DATA_W-1:0] ret_pc,
    input  logic [DATA_W-1:0] ret_inst,
    input  logic              ret_reg_wr,
    input  logic [REG_W-1:0]  ret_reg_sel,
    input  logic [DATA_W-1:0] ret_reg_data,
    input  logic              ret_mem_rd,
    input  logic              ret_mem_wr,
    input  logic [DATA_W-1:0] ret_mem_addr,
    input  logic [DATA_W-1:0] ret_mem_data,
    input  logic              ret_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [CNT_W-1:0]  out_inum,
    output logic [CNT_W-1:0]  out_cycle,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic [DATA_W-1:0] out_reg_data,
    output logic [DATA_W-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [REG_W-1:0]  out_reg_sel,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic              halted,
    output logic              done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        KIND_NOP  = 3'd0,
        KIND_ALU  = 3'd1,
        KIND_LD   = 3'd2,
        KIND_ST   = 3'd3,
        KIND_STU  = 3'd4,
        KIND_HALT = 3'd5
    } recKindT;

    typedef struct packed {
        recKindT            kind;
        logic [CNT_W-1:0]   inum;
        logic [CNT_W-1:0]   cycle;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  inst;
        logic [REG_W-1:0]   regSel;
        logic [DATA_W-1:0]  regData;
        logic [DATA_W-1:0]  memAddr;
        logic [DATA_W-1:0]  memData;
    } recT;

    recT             mem [DEPTH];
    recT             newRec;
    recT             pendRec;
    recT             pushRec;
    recT             headRec;
    recKindT         newKind;
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [AW:0]     count;
    logic            pendValid;
    logic [CNT_W-1:0] cycleCtr;
    logic [CNT_W-1:0] instCtr;
    logic            accept;
    logic            pop;
    logic            room;
    logic            pushPend;
    logic            pushNew;
    logic            push;
    logic            drop;
    logic            pendLoad;

    // Classify the event, build its record and decide push, drop or park-as-pending.
    always_comb begin
        newKind = KIND_NOP;
        if (ret_halt)                       newKind = KIND_HALT;
        else if (ret_reg_wr && ret_mem_wr)  newKind = KIND_STU;
        else if (ret_mem_wr)                newKind = KIND_ST;
        else if (ret_reg_wr && ret_mem_rd)  newKind = KIND_LD;
        else if (ret_reg_wr)                newKind = KIND_ALU;

        newRec = '{kind: newKind, inum: instCtr, cycle: cycleCtr, pc: ret_pc,
                   inst: ret_inst, regSel: ret_reg_sel, regData: ret_reg_data,
                   memAddr: ret_mem_addr, memData: ret_mem_data};

        accept   = ret_valid && !halted;
        pop      = (count != '0) && out_ready;
        room     = (count != FULL_CNT) || pop;
        pushPend = pendValid && room;
        pushNew  = accept && room && !pendValid;
        push     = pushPend || pushNew;
        drop     = accept && !room && !ret_halt;
        pendLoad = accept && !room && ret_halt;
        pushRec  = pushPend ? pendRec : newRec;
    end

    // Storage is reset so every output reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wrPtr] <= pushRec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            pendValid  <= 1'b0;
            pendRec    <= '0;
            cycleCtr   <= '0;
            instCtr    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            halted     <= 1'b0;
        end else begin
            cycleCtr <= cycleCtr + 1'b1;
            if (accept)  instCtr <= instCtr + 1'b1;
            if (push)    wrPtr   <= wrPtr + 1'b1;
            if (pop)     rdPtr   <= rdPtr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (pendLoad) begin
                pendValid <= 1'b1;
                pendRec   <= newRec;
            end else if (pushPend) begin
                pendValid <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
            if (accept && ret_halt) halted <= 1'b1;
        end
    end

    assign headRec      = mem[rdPtr];
    assign out_valid    = count != '0;
    assign out_kind     = headRec.kind;
    assign out_inum     = headRec.inum;
    assign out_cycle    = headRec.cycle;
    assign out_pc       = headRec.pc;
    assign out_inst     = headRec.inst;
    assign out_reg_sel  = headRec.regSel;
    assign out_reg_data = headRec.regData;
    assign out_mem_addr = headRec.memAddr;
    assign out_mem_data = headRec.memData;
    assign done         = halted && (count == '0) && !pendValid;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed bench for retire_trace_fifo: classification, ordering, overflow,
// pending halt, full push+pop and asynchronous reset.
module tb_retire_trace_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ret_valid = 1'b0;
    logic [15:0] ret_pc = '0;
    logic [15:0] ret_inst = '0;
    logic        ret_reg_wr = 1'b0;
    logic [2:0]  ret_reg_sel = '0;
    logic [15:0] ret_reg_data = '0;
    logic        ret_mem_rd = 1'b0;
    logic        ret_mem_wr = 1'b0;
    logic [15:0] ret_mem_addr = '0;
    logic [15:0] ret_mem_data = '0;
    logic        ret_halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_kind;
    logic [31:0] out_inum;
    logic [31:0] out_cycle;
    logic [15:0] out_pc;
    logic [15:0] out_inst;
    logic [15:0] out_reg_data;
    logic [15:0] out_mem_addr;
    logic [15:0] out_mem_data;
    logic [2:0]  out_reg_sel;
    logic        overflow;
    logic [15:0] drop_count;
    logic        halted;
    logic        done;

    int          total = 0;
    int          bad = 0;
    logic [31:0] prevCycle;
    logic [2:0]  seqKinds [4] = '{3'd2, 3'd3, 3'd4, 3'd0};

    retire_trace_fifo dut (
        .clk(clk), .rst_n(rst_n),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
        .ret_reg_wr(ret_reg_wr), .ret_reg_sel(ret_reg_sel), .ret_reg_data(ret_reg_data),
        .ret_mem_rd(ret_mem_rd), .ret_mem_wr(ret_mem_wr), .ret_mem_addr(ret_mem_addr),
        .ret_mem_data(ret_mem_data), .ret_halt(ret_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_inum(out_inum), .out_cycle(out_cycle), .out_pc(out_pc), .out_inst(out_inst),
        .out_reg_data(out_reg_data), .out_mem_addr(out_mem_addr),
        .out_mem_data(out_mem_data), .out_reg_sel(out_reg_sel),
        .overflow(overflow), .drop_count(drop_count), .halted(halted), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
        end
    endtask

    // Drive one retire event; kind code selects the control bits that should produce it.
    task automatic applyStimulus(input logic valid, input logic [2:0] kind,
                                 input logic [15:0] data);
        ret_valid    = valid;
        ret_reg_wr   = (kind == 3'd1) || (kind == 3'd2) || (kind == 3'd4);
        ret_mem_rd   = (kind == 3'd2);
        ret_mem_wr   = (kind == 3'd3) || (kind == 3'd4);
        ret_halt     = (kind == 3'd5);
        ret_reg_sel  = 3'd3;
        ret_reg_data = data;
        ret_pc       = 16'h0002;
        ret_inst     = data ^ 16'h5A5A;
        ret_mem_addr = data + 16'h0100;
        ret_mem_data = data;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        #2 rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0);
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fillAlu(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 3'd1, 16'h1000 + 16'(i));
            tick();
        end
        applyStimulus(1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        $display("[TB] start");
        // Reset state
        doReset();
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_drop", 64'(drop_count), 64'd0);

        // Single ALU retire
        applyStimulus(1'b1, 3'd1, 16'h1234);
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0);
        checkOutput("alu_valid", 64'(out_valid), 64'd1);
        checkOutput("alu_kind", 64'(out_kind), 64'd1);
        checkOutput("alu_inum", 64'(out_inum), 64'd0);
        checkOutput("alu_sel", 64'(out_reg_sel), 64'd3);
        checkOutput("alu_data", 64'(out_reg_data), 64'h1234);
        checkOutput("alu_pc", 64'(out_pc), 64'h0002);
        tick();
        checkOutput("alu_hold", 64'(out_inum), 64'd0);
        checkOutput("alu_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("alu_popped", 64'(out_valid), 64'd0);

        // LD, ST, STU, NOP streamed with the sink always ready
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, seqKinds[i], 16'h2000 + 16'(i));
            tick();
            checkOutput("seq_valid", 64'(out_valid), 64'd1);
            checkOutput("seq_kind", 64'(out_kind), 64'(seqKinds[i]));
            checkOutput("seq_inum", 64'(out_inum), 64'(i));
            if (i > 0) checkOutput("seq_cycle", 64'(out_cycle), 64'(prevCycle + 32'd1));
            prevCycle = out_cycle;
        end
        applyStimulus(1'b0, 3'd0, 16'h0);
        tick();
        checkOutput("seq_empty", 64'(out_valid), 64'd0);
        checkOutput("seq_ovf", 64'(overflow), 64'd0);

        // Overflow: 10 retires into 8 entries with the sink stalled
        doReset();
        fillAlu(8);
        checkOutput("full_noovf", 64'(overflow), 64'd0);
        fillAlu(2);
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        checkOutput("ovf_drops", 64'(drop_count), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("ovf_drain_valid", 64'(out_valid), 64'd1);
            checkOutput("ovf_drain_inum", 64'(out_inum), 64'(i));
            tick();
        end
        checkOutput("ovf_drained", 64'(out_valid), 64'd0);
        checkOutput("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO: retire and pop in the same cycle
        doReset();
        fillAlu(8);
        applyStimulus(1'b1, 3'd1, 16'hBEEF);
        out_ready = 1'b1;
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0);
        checkOutput("pp_noovf", 64'(overflow), 64'd0);
        checkOutput("pp_drops", 64'(drop_count), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("pp_drain_inum", 64'(out_inum), 64'(i));
            if (i == 8) checkOutput("pp_tail_data", 64'(out_reg_data), 64'hBEEF);
            tick();
        end
        checkOutput("pp_drained", 64'(out_valid), 64'd0);

        // Halt into a full FIFO parks as pending until a slot frees
        doReset();
        fillAlu(8);
        applyStimulus(1'b1, 3'd5, 16'h0);
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0);
        checkOutput("h_halted", 64'(halted), 64'd1);
        checkOutput("h_done", 64'(done), 64'd0);
        checkOutput("h_noovf", 64'(overflow), 64'd0);
        checkOutput("h_drops", 64'(drop_count), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("h_pop1_inum", 64'(out_inum), 64'd1);
        tick();
        checkOutput("h_done_busy", 64'(done), 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checkOutput("h_drain_inum", 64'(out_inum), 64'(i));
            if (i == 8) checkOutput("h_last_kind", 64'(out_kind), 64'd5);
            tick();
        end
        checkOutput("h_drained", 64'(out_valid), 64'd0);
        checkOutput("h_done_set", 64'(done), 64'd1);

        // Events after halt are ignored
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'd1, 16'h3000);
            tick();
        end
        applyStimulus(1'b0, 3'd0, 16'h0);
        checkOutput("post_valid", 64'(out_valid), 64'd0);
        checkOutput("post_drops", 64'(drop_count), 64'd0);
        checkOutput("post_done", 64'(done), 64'd1);

        // Asynchronous reset mid-cycle clears everything immediately
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_halted", 64'(halted), 64'd0);
        checkOutput("arst_done", 64'(done), 64'd0);
        checkOutput("arst_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_kind", 64'(out_kind), 64'd0);
        checkOutput("arst_inum", 64'(out_inum), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Synthesizable retirement monitor for the pipelined core.
- Samples one retire event per cycle from the writeback/memory boundary: PC, instruction, register write, memory access and halt.
- Classifies each event, stamps it with an instruction number and cycle number, and buffers it in a parametrised FIFO.
- A downstream trace sink (bench or debug port) drains the FIFO through a valid/ready handshake.

Parameters:
- DATA_W, 16, width of PC, instruction, register data, memory address and memory data.
- REG_W, 3, register-select width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the instruction and cycle counters.
- DROP_W, 16, width of the dropped-record counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ret_valid  in  1  retire event present this cycle
- ret_pc  in  DATA_W  PC of retiring instruction
- ret_inst  in  DATA_W  instruction word
- ret_reg_wr  in  1  register file write
- ret_reg_sel  in  REG_W  destination register
- ret_reg_data  in  DATA_W  register write data
- ret_mem_rd  in  1  memory read
- ret_mem_wr  in  1  memory write
- ret_mem_addr  in  DATA_W  memory address
- ret_mem_data  in  DATA_W  memory write data
- ret_halt  in  1  halt retiring
- out_valid  out  1  head record valid
- out_ready  in  1  sink accepts head
- out_kind  out  3  record class
- out_inum  out  CNT_W  instruction number
- out_cycle  out  CNT_W  cycle stamp
- out_pc, out_inst, out_reg_data, out_mem_addr, out_mem_data  out  DATA_W each  captured fields
- out_reg_sel  out  REG_W  captured register select
- overflow  out  1  sticky: a record was dropped
- drop_count  out  DROP_W  records dropped, saturating
- halted  out  1  halt retire accepted
- done  out  1  halted and FIFO fully drained

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, FIFO empty, counters 0.
- cycle_ctr: increments every cycle out of reset and wraps at 2^CNT_W.
- Record stamp: the value of cycle_ctr in the cycle the event is sampled.
- Accepted event: ret_valid=1 and halted=0. Events with halted=1 are ignored entirely (not counted, not dropped).
- inst_ctr: increments on every accepted event, including dropped ones, so gaps in out_inum expose drops. The first record has inum 0.
- out_kind, first match wins:
  - 5 HALT: ret_halt
  - 4 STU: reg_wr & mem_wr
  - 3 ST: mem_wr
  - 2 LD: reg_wr & mem_rd
  - 1 ALU: reg_wr
  - 0 NOP/BRANCH: otherwise
- Push/pop:
  - Push happens when an event is accepted and (count<DEPTH, or count==DEPTH with a pop in the same cycle).
  - Pop happens when out_valid & out_ready.
  - Simultaneous push and pop leaves count unchanged and is legal both when full and when empty. When empty, the pushed record is not bypassed.
- Latency: a record is visible on out_* the cycle after it is sampled. Outputs come from registered storage. The head and its fields are stable while out_valid=1 and out_ready=0.
- out_valid = count!=0.
- Non-halt event with the FIFO full and no pop: the record is dropped, overflow is set (cleared only by reset), and drop_count increments (saturates at all-ones).
- Halt event:
  - halted is set the next cycle.
  - A HALT record is never dropped. If the FIFO is full without a pop, the record is held in a one-entry pending register and pushed in the first cycle a slot frees. A pending push has priority; no further events can arrive because halted=1.
- done = halted & FIFO empty & no pending halt.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- Reset mid-operation: FIFO contents are discarded, all flags and counters clear, and the pending halt is lost.

Test Plan:
- Reset, then one ALU retire (pc=0x0002, reg_wr=1, sel=3, data=0x1234) -> next cycle out_valid=1, kind=1, inum=0, out_reg_sel=3, out_reg_data=0x1234.
- Retire sequence LD, ST, STU, NOP with out_ready=1 -> kinds 2, 3, 4, 0 in order, inum 0..3, cycle stamps strictly increasing, no overflow.
- DEPTH=8, out_ready=0, 10 back-to-back ALU retires -> 8 records held (inum 0..7), overflow=1, drop_count=2. Then draining with out_ready=1 yields exactly inum 0..7.
- FIFO full with out_ready=0, then halt retires -> halted=1, done=0, pending halt held. Pop one entry -> HALT record enters the FIFO. Drain all -> final record kind=5, then done=1.
- Full FIFO, retire and pop in the same cycle -> count stays 8, no drop, the new record lands at the tail.
- After halted=1, drive 3 more ret_valid pulses -> no pushes, inum unchanged, drop_count unchanged. Then assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately.
